// File: rtl/vga_frame_loader.sv
// Byte-stream to framebuffer write stage: after a sync byte, unpacks each payload byte into
// two 4-bit pixels written in raster order; aborts if the stream stalls for too long.
module vga_frame_loader #(
    parameter int unsigned IMG_W          = 640,
    parameter int unsigned IMG_H          = 480,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    localparam int unsigned NUM_PIX       = IMG_W * IMG_H,
    localparam int unsigned ADDR_W        = $clog2(NUM_PIX)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              error
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    if (NUM_PIX % 2 != 0) begin : g_odd_pixels
        $error("IMG_W*IMG_H must be even");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StLoadHi, StLoadLo} state_e;

    state_e            state;
    logic [ADDR_W-1:0] cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [3:0]        pending;
    logic              xfer;

    assign xfer = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            cnt        <= '0;
            to_cnt     <= '0;
            pending    <= '0;
            s_ready    <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            error      <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            error      <= 1'b0;
            // busy stays up through the done/error pulse; a new sync below overrides the clear
            if (frame_done || error) begin
                busy <= 1'b0;
            end
            unique case (state)
                StIdle: begin
                    s_ready <= 1'b1;
                    if (xfer && s_data == SYNC_BYTE) begin
                        state  <= StLoadHi;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        to_cnt <= '0;
                    end
                end
                StLoadHi: begin
                    if (xfer) begin
                        wr_en   <= 1'b1;
                        wr_addr <= cnt;
                        wr_data <= s_data[7:4];
                        pending <= s_data[3:0];
                        to_cnt  <= '0;
                        s_ready <= 1'b0;
                        state   <= StLoadLo;
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        error  <= 1'b1;
                        to_cnt <= '0;
                        state  <= StIdle;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                StLoadLo: begin
                    wr_en   <= 1'b1;
                    wr_addr <= cnt + ADDR_W'(1);
                    wr_data <= pending;
                    cnt     <= cnt + ADDR_W'(2);
                    s_ready <= 1'b1;
                    if (cnt == ADDR_W'(NUM_PIX - 2)) begin
                        frame_done <= 1'b1;
                        state      <= StIdle;
                    end else begin
                        state <= StLoadHi;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_loader.sv
// Directed bench for vga_frame_loader on a 4x2 image with a 16-cycle stall timeout.
module tb_vga_frame_loader;

    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        s_data = 8'h00;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_data;
    logic              busy;
    logic              frame_done;
    logic              error;

    int n_checks = 0;
    int n_errors = 0;

    logic [ADDR_W-1:0] wlog_a[$];
    logic [3:0]        wlog_d[$];
    int n_done = 0;
    int n_err = 0;
    int n_done_misplaced = 0;
    int n_both = 0;

    vga_frame_loader #(
        .IMG_W         (4),
        .IMG_H         (2),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .frame_done(frame_done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Framebuffer-side monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (wr_en) begin
            wlog_a.push_back(wr_addr);
            wlog_d.push_back(wr_data);
        end
        if (frame_done) begin
            n_done++;
            if (!(wr_en && wr_addr == 3'd7)) n_done_misplaced++;
        end
        if (error) n_err++;
        if (frame_done && error) n_both++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time (got timeout, required finish)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wlog_a.delete();
        wlog_d.delete();
        n_done = 0;
        n_err = 0;
    endtask

    task automatic check_reset_values(input string pre);
        check({pre, "_s_ready"}, 32'(s_ready), 0);
        check({pre, "_wr_en"}, 32'(wr_en), 0);
        check({pre, "_wr_addr"}, 32'(wr_addr), 0);
        check({pre, "_wr_data"}, 32'(wr_data), 0);
        check({pre, "_busy"}, 32'(busy), 0);
        check({pre, "_frame_done"}, 32'(frame_done), 0);
        check({pre, "_error"}, 32'(error), 0);
    endtask

    // Pixel i of the expected sequence is pix[31-4i -: 4]
    task automatic check_writes(input string tag, input logic [31:0] pix, input int n);
        check({tag, "_count"}, 32'(wlog_a.size()), 32'(n));
        for (int i = 0; i < n && i < wlog_a.size(); i++) begin
            check({tag, "_addr"}, 32'(wlog_a[i]), 32'(i));
            check({tag, "_data"}, 32'(wlog_d[i]), 32'(pix[31-4*i -: 4]));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data = b;
        t = 0;
        while (!s_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", 32'(t < 40), 1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] bytes, input logic [15:0] gaps);
        send_byte(8'hA5, 0);
        for (int i = 0; i < 4; i++) send_byte(bytes[31-8*i -: 8], int'(gaps[15-4*i -: 4]));
    endtask

    logic [10:0] exp_rdy;
    logic [10:0] exp_busy;
    logic [7:0]  seq [5];

    initial begin
        // Reset values and first post-reset cycle
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(s_ready), 1);

        // 1: back-to-back stream with s_valid held high
        clear_log();
        seq = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78};
        exp_rdy = 11'b11010101011;
        exp_busy = 11'b01111111110;
        begin
            int bi;
            bi = 0;
            for (int c = 0; c < 11; c++) begin
                check("t1_s_ready", 32'(s_ready), 32'(exp_rdy[10-c]));
                check("t1_busy", 32'(busy), 32'(exp_busy[10-c]));
                if (bi < 5) begin
                    s_valid = 1'b1;
                    s_data = seq[bi];
                end else begin
                    s_valid = 1'b0;
                end
                if (s_valid && s_ready) bi++;
                @(negedge clk);
            end
        end
        check_writes("t1", 32'h12345678, 8);
        check("t1_done", 32'(n_done), 1);
        check("t1_err", 32'(n_err), 0);

        // 2: junk bytes before sync are discarded
        clear_log();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        repeat (2) @(negedge clk);
        check("t2_no_write", 32'(wlog_a.size()), 0);
        check("t2_busy_idle", 32'(busy), 0);
        send_frame(32'h9ABCDEF0, 16'h0000);
        repeat (4) @(negedge clk);
        check_writes("t2", 32'h9ABCDEF0, 8);
        check("t2_done", 32'(n_done), 1);

        // 3: gaps on the payload, one leaving 15 idle cycles (just under timeout)
        clear_log();
        send_byte(8'hA5, 2);
        send_byte(8'h12, 3);
        send_byte(8'h34, 0);
        send_byte(8'h56, 16);
        send_byte(8'h78, 7);
        repeat (4) @(negedge clk);
        check_writes("t3", 32'h12345678, 8);
        check("t3_err", 32'(n_err), 0);
        check("t3_done", 32'(n_done), 1);

        // 4: stall past timeout aborts the frame
        clear_log();
        send_byte(8'hA5, 0);
        send_byte(8'h12, 0);
        repeat (20) @(negedge clk);
        check_writes("t4", 32'h12000000, 2);
        check("t4_err", 32'(n_err), 1);
        check("t4_done", 32'(n_done), 0);
        check("t4_busy", 32'(busy), 0);
        send_byte(8'h33, 0);
        repeat (4) @(negedge clk);
        check("t4_ignored", 32'(wlog_a.size()), 2);
        check("t4_busy_after", 32'(busy), 0);

        // 5: reset mid-frame drops the pending low nibble
        clear_log();
        send_byte(8'hA5, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("t5_reset");
        reset = 1'b0;
        @(negedge clk);
        check_writes("t5_partial", 32'h12300000, 3);
        check("t5_ready", 32'(s_ready), 1);
        clear_log();
        send_frame(32'h12345678, 16'h0100);
        repeat (4) @(negedge clk);
        check_writes("t5", 32'h12345678, 8);
        check("t5_done", 32'(n_done), 1);

        // 6: sync value inside the payload is plain pixel data
        clear_log();
        send_frame(32'h12A55678, 16'h0000);
        repeat (4) @(negedge clk);
        check_writes("t6", 32'h12A55678, 8);
        check("t6_done", 32'(n_done), 1);

        check("done_with_last_write", 32'(n_done_misplaced), 0);
        check("done_and_error_together", 32'(n_both), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
